// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA debug-display row fetch path.
package vga_pkg;
  localparam int         CHARS_PER_LINE = 44;
  localparam logic [4:0] CHAR_SPACE     = 5'd16;
  localparam logic [5:0] LAST_COL       = 6'(CHARS_PER_LINE - 1);
  localparam logic [5:0] FIELD_PITCH    = 6'd9;
  localparam logic [4:0][5:0] FIELD_START = {6'd36, 6'd27, 6'd18, 6'd9, 6'd0};

  typedef logic [4:0] char_code_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE,
    ST_EMIT
  } fetch_state_e;
endpackage

// File: rtl/vga_col_map.sv
// Maps a column of a captured 160-bit debug row to a character code.
module vga_col_map
  import vga_pkg::*;
(
  input  logic [5:0]   col,
  input  logic [159:0] row_data,
  input  logic         blank_reg,
  input  logic         blank_mem,
  output char_code_t   code
);
  logic [5:0]  fld_w;
  logic [2:0]  fld;
  logic [5:0]  off;
  logic [31:0] word;
  logic        blank;
  logic [3:0]  nib;

  // Fields sit on a 9-column pitch: 8 hex digits plus a separating space.
  always_comb begin
    fld_w = col / FIELD_PITCH;
    fld   = (fld_w > 6'd4) ? 3'd4 : fld_w[2:0];
    off   = col - FIELD_START[fld];
    case (fld)
      3'd0:    word = row_data[159:128];
      3'd1:    word = row_data[127:96];
      3'd2:    word = row_data[95:64];
      3'd3:    word = row_data[63:32];
      default: word = row_data[31:0];
    endcase
    blank = (fld == 3'd2) ? blank_reg : blank_mem;
    nib   = word[{3'd7 - off[2:0], 2'b00} +: 4];
    code  = (off == 6'd8 || blank) ? CHAR_SPACE : {1'b0, nib};
  end
endmodule

// File: rtl/vga_row_fetcher.sv
// Fetches one debug-RAM row per text line and streams it as 44 character codes.
module vga_row_fetcher
  import vga_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int REG_ROWS     = 32,
  parameter int MEM_ROWS     = 46
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         line_req,
  input  logic [5:0]   line_idx,
  output logic [5:0]   read_address,
  input  logic [159:0] ram_out,
  output logic         char_valid,
  input  logic         char_ready,
  output char_code_t   char_code,
  output logic [5:0]   char_col,
  output logic         char_last,
  output logic         busy,
  output logic         line_drop
);
  fetch_state_e state, state_nxt;
  logic [1:0]   wait_cnt;
  logic [159:0] row_q_data;
  logic         blank_reg, blank_mem;
  logic [5:0]   col;
  logic         hs;

  assign char_valid = (state == ST_EMIT);
  assign busy       = (state != ST_IDLE);
  assign hs         = char_valid && char_ready;
  assign char_col   = col;
  assign char_last  = char_valid && (col == LAST_COL);
  assign line_drop  = line_req && busy;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (line_req) state_nxt = ST_WAIT;
      ST_WAIT:    if (wait_cnt == 2'd0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_EMIT;
      ST_EMIT:    if (hs && col == LAST_COL) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // read_address doubles as the latched row index for the whole line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_address <= '0;
      wait_cnt     <= '0;
      row_q_data   <= '0;
      blank_reg    <= 1'b0;
      blank_mem    <= 1'b0;
      col          <= '0;
    end else begin
      case (state)
        ST_IDLE: if (line_req) begin
          read_address <= line_idx;
          wait_cnt     <= 2'(READ_LATENCY - 1);
        end
        ST_WAIT: if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
        ST_CAPTURE: begin
          row_q_data <= ram_out;
          blank_reg  <= int'(read_address) >= REG_ROWS;
          blank_mem  <= int'(read_address) >= MEM_ROWS;
          col        <= '0;
        end
        ST_EMIT: if (hs) col <= (col == LAST_COL) ? 6'd0 : col + 6'd1;
        default: ;
      endcase
    end
  end

  vga_col_map u_col_map (
    .col       (col),
    .row_data  (row_q_data),
    .blank_reg (blank_reg),
    .blank_mem (blank_mem),
    .code      (char_code)
  );
endmodule

// File: tb/tb_vga_row_fetcher.sv
// Scoreboard bench for vga_row_fetcher: text-rendered reference, random ready.
module tb_vga_row_fetcher;
  localparam int RL = 1, REG_ROWS = 32, MEM_ROWS = 46;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         line_req;
  logic [5:0]   line_idx;
  logic [5:0]   read_address;
  logic [159:0] ram_out;
  logic         char_valid, char_ready, char_last, busy, line_drop;
  logic [4:0]   char_code;
  logic [5:0]   char_col;

  logic [159:0] mem [64];
  assign ram_out = mem[read_address];

  typedef struct packed { logic [4:0] code; logic [5:0] col; logic last; } exp_t;
  exp_t sb[$];

  int n_checks = 0, n_pass = 0;
  int mode = 0;

  vga_row_fetcher #(.READ_LATENCY(RL), .REG_ROWS(REG_ROWS), .MEM_ROWS(MEM_ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_idx(line_idx),
    .read_address(read_address), .ram_out(ram_out), .char_valid(char_valid),
    .char_ready(char_ready), .char_code(char_code), .char_col(char_col),
    .char_last(char_last), .busy(busy), .line_drop(line_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // Reference: render the row as text exactly as it would appear on screen.
  function automatic logic [4:0] ref_code(input int row, input logic [159:0] w, input int col);
    string blank8 = "        ";
    string ih, il, rg, dh, dl, s;
    int ch;
    ih = (row >= MEM_ROWS) ? blank8 : $sformatf("%08h", w[159:128]);
    il = (row >= MEM_ROWS) ? blank8 : $sformatf("%08h", w[127:96]);
    rg = (row >= REG_ROWS) ? blank8 : $sformatf("%08h", w[95:64]);
    dh = (row >= MEM_ROWS) ? blank8 : $sformatf("%08h", w[63:32]);
    dl = (row >= MEM_ROWS) ? blank8 : $sformatf("%08h", w[31:0]);
    s  = {ih, " ", il, " ", rg, " ", dh, " ", dl};
    ch = int'(s[col]);
    if (ch == 32)  return 5'd16;
    if (ch >= 97)  return 5'(ch - 97 + 10);
    return 5'(ch - 48);
  endfunction

  task automatic push_line(input int row);
    exp_t e;
    for (int c = 0; c < 44; c++) begin
      e.code = ref_code(row, mem[row], c);
      e.col  = 6'(c);
      e.last = (c == 43);
      sb.push_back(e);
    end
  endtask

  // Called at posedge+2; issues a request and waits for the line to finish.
  task automatic send_line(input int row, input bit timing);
    int n, m;
    bit bad;
    push_line(row);
    line_req = 1'b1; line_idx = 6'(row);
    @(posedge clk); #2; line_req = 1'b0;
    check("accept_busy", busy === 1'b1, $sformatf("row %0d busy got %b want 1", row, busy));
    n = 1; m = 1; bad = 0;
    while (!char_valid && n < 10) begin
      if (read_address !== 6'(row)) bad = 1;
      @(posedge clk); #2; n++; m++;
    end
    if (timing)
      check("first_valid_latency", n == RL + 2, $sformatf("got %0d want %0d", n, RL + 2));
    while (busy && m < 3000) begin
      if (read_address !== 6'(row)) bad = 1;
      @(posedge clk); #2; m++;
    end
    check("line_done", !busy, $sformatf("row %0d busy still %b after %0d cycles", row, busy, m));
    check("addr_hold", !bad, $sformatf("row %0d read_address %0d", row, read_address));
    if (timing)
      check("line_cycles", m == RL + 46, $sformatf("got %0d want %0d", m, RL + 46));
    check("handshakes_44", sb.size() == 0, $sformatf("row %0d leftover %0d", row, sb.size()));
    sb.delete();
  endtask

  task automatic wait_col(input int c, output bit ok);
    int k = 0;
    while (!(char_valid && char_col == 6'(c)) && k < 2000) begin @(posedge clk); #2; k++; end
    ok = (k < 2000);
  endtask

  // Ready driver
  initial begin
    int ph = 0;
    char_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: char_ready = 1'b1;
        1: char_ready = 1'($urandom_range(0, 1));
        2: begin char_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
        default: char_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on each handshake, checks holding while stalled
  initial begin
    bit stalled = 0;
    logic [4:0] s_code;
    logic [5:0] s_col;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 0;
      else begin
        if (stalled)
          check("stall_hold", char_valid && char_code == s_code && char_col == s_col,
                $sformatf("got v%b code %0d col %0d want v1 code %0d col %0d",
                          char_valid, char_code, char_col, s_code, s_col));
        stalled = 0;
        if (char_valid && char_ready) begin
          if (sb.size() == 0)
            check("unexpected_char", 1'b0, $sformatf("col %0d code %0d with empty queue", char_col, char_code));
          else begin
            e = sb.pop_front();
            check("char", char_code == e.code && char_col == e.col && char_last == e.last,
                  $sformatf("got code %0d col %0d last %b want code %0d col %0d last %b",
                            char_code, char_col, char_last, e.code, e.col, e.last));
          end
        end else if (char_valid) begin
          stalled = 1; s_code = char_code; s_col = char_col;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int r;
    rst_n = 1'b0; line_req = 1'b0; line_idx = '0;
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
    mem[5]  = {64'h0123456789ABCDEF, 32'hDEADBEEF, 64'hFEDCBA9876543210};
    mem[40] = mem[5]; mem[50] = mem[5]; mem[63] = mem[5];
    #3;
    check("reset_outputs", char_valid === 0 && busy === 0 && line_drop === 0 && char_last === 0 &&
          read_address === 0 && char_code === 0 && char_col === 0,
          $sformatf("got v%b busy%b drop%b last%b addr %0d code %0d col %0d want all 0",
                    char_valid, busy, line_drop, char_last, read_address, char_code, char_col));
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #2;

    // directed rows and blanking boundaries, ready held high
    send_line(5, 1);
    send_line(40, 1);
    send_line(50, 1);
    send_line(63, 1);
    send_line(31, 1);
    send_line(32, 1);
    send_line(45, 1);
    send_line(46, 1);

    // 1,0,0,1 ready pattern then fully random ready
    mode = 2;
    send_line(5, 0);
    send_line(20, 0);
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, 63));
      send_line(r, 0);
    end

    // dropped requests: mid-line and on the final handshake
    mode = 0;
    @(posedge clk); #2;
    push_line(12);
    line_req = 1'b1; line_idx = 6'd12;
    @(posedge clk); #2; line_req = 1'b0;
    wait_col(10, ok);
    check("reach_col10", ok, "timeout waiting for col 10");
    line_req = 1'b1; line_idx = 6'd33; #1;
    check("drop_mid", line_drop === 1'b1, $sformatf("line_drop got %b want 1", line_drop));
    @(posedge clk); #2; line_req = 1'b0;
    check("drop_addr_kept", read_address == 6'd12, $sformatf("read_address got %0d want 12", read_address));
    wait_col(43, ok);
    check("reach_col43", ok, "timeout waiting for col 43");
    line_req = 1'b1; line_idx = 6'd33; #1;
    check("drop_last", line_drop === 1'b1 && char_last === 1'b1,
          $sformatf("line_drop %b char_last %b want 1 1", line_drop, char_last));
    @(posedge clk); #2; line_req = 1'b0;
    check("no_restart", busy === 1'b0, $sformatf("busy got %b want 0", busy));
    check("drop_line_count", sb.size() == 0, $sformatf("leftover %0d want 0", sb.size()));
    sb.delete();
    send_line(33, 1);

    // asynchronous reset during a stall at col 20
    push_line(7);
    line_req = 1'b1; line_idx = 6'd7;
    @(posedge clk); #2; line_req = 1'b0;
    wait_col(19, ok);
    check("reach_col19", ok, "timeout waiting for col 19");
    mode = 3;
    repeat (4) begin @(posedge clk); #2; end
    check("stalled_col20", char_valid && char_col == 6'd20,
          $sformatf("got v%b col %0d want v1 col 20", char_valid, char_col));
    #1; rst_n = 1'b0; #1;
    check("async_reset", char_valid === 1'b0 && busy === 1'b0,
          $sformatf("char_valid %b busy %b want 0 0", char_valid, busy));
    sb.delete();
    @(negedge clk); @(posedge clk); #2;
    rst_n = 1'b1; mode = 0;
    @(posedge clk); #2;
    check("idle_after_reset", busy === 1'b0 && char_valid === 1'b0 && char_col === 6'd0,
          $sformatf("busy %b v %b col %0d want 0 0 0", busy, char_valid, char_col));
    send_line(0, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
